// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
//
// Multi-cycle data-memory responder for the MEM-stage port of the pipeline.
// Loads and stores go to an internal word-addressed RAM. Each access takes a
// fixed number of wait states. While the access is in flight, stall is held
// high so that the MEM-stage instruction and everything behind it stay put.
//
// Parameters
//   ADDR_WIDTH   word-address bits; the RAM holds 2**ADDR_WIDTH 32-bit words
//   WAIT_STATES  WAIT cycles per access (0..15)
//
// Ports
//   clk       in   clock, rising-edge
//   reset     in   asynchronous, active-high reset
//   memread   in   load request (level, held while stall=1)
//   memwrite  in   store request (level, held while stall=1)
//   addr      in   byte address, bits [1:0] must be zero
//   wdata     in   store data
//   rdata     out  load data, registered, holds until the next load completes
//   stall     out  combinational hold request to pipeline control
//   ready     out  one-cycle completion pulse, registered
//   err       out  sticky misaligned-request flag, registered
// -----------------------------------------------------------------------------
module dmem_responder #(
    parameter int ADDR_WIDTH  = 8,
    parameter int WAIT_STATES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memread,
    input  logic        memwrite,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        stall,
    output logic        ready,
    output logic        err
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                  state_r;
    logic [3:0]              cnt_r;
    logic [ADDR_WIDTH-1:0]   idx_r;
    logic [31:0]             wdata_r;
    logic                    op_write_r;
    logic [31:0]             rdata_r;
    logic                    ready_r;
    logic                    err_r;

    // RAM contents are deliberately not reset so that they survive a reset.
    logic [31:0]             mem_r [0:(2**ADDR_WIDTH)-1];

    logic                    req_s;
    logic                    aligned_s;
    logic                    start_s;
    logic                    enter_done_s;
    logic                    acc_write_s;
    logic [ADDR_WIDTH-1:0]   req_idx_s;
    logic [ADDR_WIDTH-1:0]   acc_idx_s;
    logic [31:0]             acc_wdata_s;
    logic                    stall_s;

    // High address bits are ignored on purpose, so addresses alias.
    logic                    unused_addr_s;
    assign unused_addr_s = ^addr[31:ADDR_WIDTH+2];

    // Request decode, and selection of the access that completes on this edge.
    always_comb begin
        req_s        = memread | memwrite;
        aligned_s    = (addr[1:0] == 2'b00);
        req_idx_s    = addr[ADDR_WIDTH+1:2];
        start_s      = (state_r == ST_IDLE) && req_s && aligned_s;
        enter_done_s = 1'b0;
        acc_idx_s    = idx_r;
        acc_wdata_s  = wdata_r;
        acc_write_s  = op_write_r;
        case (state_r)
            ST_IDLE: begin
                // With zero wait states, the access completes straight from IDLE
                // and uses the live request rather than the latched copy.
                if (start_s && (WAIT_STATES == 0)) begin
                    enter_done_s = 1'b1;
                    acc_idx_s    = req_idx_s;
                    acc_wdata_s  = wdata;
                    acc_write_s  = memwrite;
                end else begin
                    enter_done_s = 1'b0;
                end
            end
            ST_WAIT: begin
                // A count of 1 or less is treated as the final WAIT cycle,
                // so a corrupted zero count cannot wrap into a long hang.
                if (cnt_r <= 4'd1) begin
                    enter_done_s = 1'b1;
                end else begin
                    enter_done_s = 1'b0;
                end
            end
            default: begin
                enter_done_s = 1'b0;
            end
        endcase
        // stall is forced low while reset is active, so outputs show their reset values at once.
        stall_s = ~reset & (start_s | (state_r == ST_WAIT));
    end

    assign stall = stall_s;
    assign rdata = rdata_r;
    assign ready = ready_r;
    assign err   = err_r;

    // Access FSM, latched request, and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            cnt_r      <= 4'd0;
            idx_r      <= '0;
            wdata_r    <= 32'd0;
            op_write_r <= 1'b0;
            rdata_r    <= 32'd0;
            ready_r    <= 1'b0;
            err_r      <= 1'b0;
        end else begin
            ready_r <= enter_done_s;
            if (enter_done_s && !acc_write_s) begin
                rdata_r <= mem_r[acc_idx_s];
            end
            if ((state_r == ST_IDLE) && req_s && !aligned_s) begin
                err_r <= 1'b1;
            end
            case (state_r)
                ST_IDLE: begin
                    if (start_s) begin
                        idx_r      <= req_idx_s;
                        wdata_r    <= wdata;
                        op_write_r <= memwrite;
                        cnt_r      <= 4'(WAIT_STATES);
                        state_r    <= (WAIT_STATES == 0) ? ST_DONE : ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    cnt_r <= cnt_r - 4'd1;
                    if (cnt_r <= 4'd1) begin
                        state_r <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // RAM write port; gated by reset so an aborted store never lands.
    always_ff @(posedge clk) begin
        if (enter_done_s && acc_write_s && !reset) begin
            mem_r[acc_idx_s] <= acc_wdata_s;
        end
    end

endmodule
